// File: rtl/disp_pkg.sv
// Shared types and helpers for the 7-seg scroll sequencer.
// Blank pattern, FSM states and the window index wrap.
package disp_pkg;

  localparam logic [7:0] BLANK = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } state_t;

  // (p+k) mod l, with p<l and k<=3<l, so one subtract suffices
  function automatic int win_idx(int p, int k, int l);
    int s;
    s = p + k;
    return (s >= l) ? s - l : s;
  endfunction

endpackage

// File: rtl/scroll_tick_gen.sv
// Scroll step prescaler: one tick every tick_div+1 enabled cycles.
// Count freezes while en is low and restarts on clr.
module scroll_tick_gen #(
  parameter int TICK_W = 26
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic [TICK_W-1:0] tick_div,
  output logic              tick
);

  logic [TICK_W-1:0] cnt;

  // >= lets a lowered tick_div take effect without wrapping
  assign tick = en && (cnt >= tick_div);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/disp_scroll_ctrl.sv
// Message buffer and scroll FSM feeding a 4-digit 7-seg driver.
// Digit outputs load the window for the new position on the same edge.
module disp_scroll_ctrl
  import disp_pkg::*;
#(
  parameter int N_MSG  = 16,
  parameter int TICK_W = 26,
  localparam int ADDR_W = $clog2(N_MSG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              clr,
  input  logic              start,
  input  logic              stop,
  input  logic [TICK_W-1:0] tick_div,
  output logic [ADDR_W:0]   len,
  output logic              full,
  output logic              busy,
  output logic [7:0]        d3,
  output logic [7:0]        d2,
  output logic [7:0]        d1,
  output logic [7:0]        d0
);

  localparam int LW = ADDR_W + 1;
  localparam int PW = ADDR_W + 2;
  localparam int NS = N_MSG + 4;

  state_t        state;
  logic [7:0]    mem  [N_MSG];
  logic [7:0]    strm [NS];
  logic [7:0]    win  [4];
  logic [7:0]    dr   [4];
  logic [PW-1:0] pos;
  logic [PW-1:0] big_l;
  logic [PW-1:0] next_pos;
  logic [PW-1:0] wp;
  logic          tick;
  logic          run_en;
  logic          restart;
  logic          wr_ok;

  assign big_l   = PW'(len) + PW'(4);
  assign full    = (len == LW'(N_MSG));
  assign busy    = (state != IDLE);
  assign run_en  = (state == RUN) && !clr && !stop;
  assign restart = clr || (state == IDLE);
  assign wr_ok   = (state == IDLE) && wr_en && !clr
                && !start && !stop && !full;

  assign d3 = dr[0];
  assign d2 = dr[1];
  assign d1 = dr[2];
  assign d0 = dr[3];

  scroll_tick_gen #(
    .TICK_W(TICK_W)
  ) u_tick (
    .clk     (clk),
    .reset   (reset),
    .clr     (restart),
    .en      (run_en),
    .tick_div(tick_div),
    .tick    (tick)
  );

  always_comb begin
    for (int i = 0; i < NS; i++) strm[i] = BLANK;
    for (int i = 0; i < N_MSG; i++) begin
      if (LW'(i) < len) strm[i] = mem[i];
    end
    next_pos = (pos == big_l - 1'b1) ? '0 : pos + 1'b1;
    wp = (state == IDLE) ? '0 : next_pos;
    for (int k = 0; k < 4; k++) begin
      win[k] = strm[PW'(win_idx(int'(wp), k, int'(big_l)))];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[len[ADDR_W-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      state <= IDLE;
      len   <= '0;
      pos   <= '0;
      for (int k = 0; k < 4; k++) dr[k] <= BLANK;
    end else begin
      unique case (state)
        IDLE: begin
          if (!stop && start && len != '0) begin
            state <= RUN;
            pos   <= '0;
            for (int k = 0; k < 4; k++) dr[k] <= win[k];
          end else if (wr_ok) begin
            len <= len + 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            state <= HOLD;
          end else if (tick) begin
            pos <= next_pos;
            for (int k = 0; k < 4; k++) dr[k] <= win[k];
          end
        end
        HOLD: begin
          if (stop) begin
            state <= IDLE;
            pos   <= '0;
            for (int k = 0; k < 4; k++) dr[k] <= BLANK;
          end else if (start) begin
            state <= RUN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_disp_scroll_ctrl.sv
// Bench for disp_scroll_ctrl: vector table, corner sequences
// and a randomized run against a queue-based reference model.
module tb_disp_scroll_ctrl;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        reset, wr_en, clr, start, stop;
  logic [7:0]  wr_data;
  logic [25:0] tick_div;
  logic [4:0]  len;
  logic        full, busy;
  logic [7:0]  d3, d2, d1, d0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  disp_scroll_ctrl #(
    .N_MSG (N),
    .TICK_W(26)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .clr     (clr),
    .start   (start),
    .stop    (stop),
    .tick_div(tick_div),
    .len     (len),
    .full    (full),
    .busy    (busy),
    .d3      (d3),
    .d2      (d2),
    .d1      (d1),
    .d0      (d0)
  );

  typedef struct {
    logic        wr;
    logic [7:0]  wd;
    logic        c, s, p;
    int          wt;
    logic [31:0] ed;
    logic        eb;
    int          el;
  } vec_t;

  vec_t tbl[$];

  // reference model: message queue, mode 0/1/2 = idle/run/hold
  logic [7:0] mq[$];
  int m_mode, m_pos, m_cnt;

  function automatic vec_t mk(logic w, logic [7:0] wd, logic c,
                              logic s, logic p, int wt,
                              logic [31:0] ed, logic eb, int el);
    vec_t v;
    v.wr = w; v.wd = wd; v.c = c; v.s = s; v.p = p;
    v.wt = wt; v.ed = ed; v.eb = eb; v.el = el;
    return v;
  endfunction

  function automatic logic [31:0] dv();
    return {d3, d2, d1, d0};
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [7:0] wd,
                       input logic c, input logic s, input logic p);
    wr_en = w; wr_data = wd; clr = c; start = s; stop = p;
    cyc();
    wr_en = 0; clr = 0; start = 0; stop = 0;
  endtask

  function automatic logic [7:0] m_s(int i);
    return (i < mq.size()) ? mq[i] : 8'hFF;
  endfunction

  function automatic logic [31:0] m_win();
    int l;
    if (m_mode == 0) return 32'hFFFF_FFFF;
    l = mq.size() + 4;
    return {m_s(m_pos), m_s((m_pos + 1) % l),
            m_s((m_pos + 2) % l), m_s((m_pos + 3) % l)};
  endfunction

  task automatic m_step(input logic w, input logic [7:0] wd,
                        input logic c, input logic s, input logic p,
                        input int td);
    int l;
    l = mq.size() + 4;
    if (c) begin
      mq.delete(); m_mode = 0; m_pos = 0; m_cnt = 0;
    end else begin
      case (m_mode)
        0: if (!p) begin
          if (s) begin
            if (mq.size() > 0) begin
              m_mode = 1; m_pos = 0; m_cnt = 0;
            end
          end else if (w && mq.size() < N) begin
            mq.push_back(wd);
          end
        end
        1: if (p) m_mode = 2;
           else if (m_cnt >= td) begin
             m_cnt = 0; m_pos = (m_pos + 1) % l;
           end else m_cnt++;
        default: if (p) begin
          m_mode = 0; m_pos = 0;
        end else if (s) m_mode = 1;
      endcase
    end
  endtask

  logic [31:0] short_seq [5];
  logic [7:0]  msg5 [5];

  initial begin
    logic       w, c, s, p;
    logic [7:0] wd;

    reset = 1; wr_en = 0; wr_data = 0; clr = 0;
    start = 0; stop = 0; tick_div = 26'd3;
    cyc(); cyc();
    reset = 0;
    chk("reset_d", dv(), 32'hFFFF_FFFF);
    chk("reset_busy", busy, 0);
    chk("reset_len", len, 0);
    chk("reset_full", full, 0);

    msg5 = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99};
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1, msg5[i], 0, 0, 0, 0, 32'hFFFF_FFFF, 0, i + 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0,  32'hC0F9A4B0, 1, 5));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3,  32'hF9A4B099, 1, 5));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3,  32'hA4B099FF, 1, 5));
    tbl.push_back(mk(0, 0, 0, 0, 0, 27, 32'hC0F9A4B0, 1, 5));
    tbl.push_back(mk(1, 8'h55, 0, 0, 0, 0, 32'hC0F9A4B0, 1, 5));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  32'hC0F9A4B0, 1, 5));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0,  32'hC0F9A4B0, 1, 5));
    tbl.push_back(mk(0, 0, 0, 0, 0, 49, 32'hC0F9A4B0, 1, 5));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0,  32'hC0F9A4B0, 1, 5));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  32'hC0F9A4B0, 1, 5));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  32'hF9A4B099, 1, 5));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0,  32'hF9A4B099, 1, 5));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0,  32'hFFFF_FFFF, 0, 5));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0,  32'hFFFF_FFFF, 0, 5));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0,  32'hC0F9A4B0, 1, 5));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0,  32'hC0F9A4B0, 1, 5));
    tbl.push_back(mk(0, 0, 0, 0, 0, 5,  32'hC0F9A4B0, 1, 5));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0,  32'hC0F9A4B0, 1, 5));
    tbl.push_back(mk(0, 0, 1, 1, 1, 0,  32'hFFFF_FFFF, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0,  32'hFFFF_FFFF, 0, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].wr, tbl[i].wd, tbl[i].c, tbl[i].s, tbl[i].p);
      repeat (tbl[i].wt) cyc();
      chk($sformatf("vec%0d_d", i), dv(), tbl[i].ed);
      chk($sformatf("vec%0d_busy", i), busy, tbl[i].eb);
      chk($sformatf("vec%0d_len", i), len, tbl[i].el);
    end

    // fill past capacity, then scroll to the last stored pattern
    for (int i = 0; i < 17; i++) drive(1, 8'(i + 1), 0, 0, 0);
    chk("full_len", len, 16);
    chk("full_flag", full, 1);
    tick_div = 26'd0;
    drive(0, 0, 0, 1, 0);
    chk("full_win0", dv(), 32'h01020304);
    repeat (15) cyc();
    chk("full_win15", dv(), 32'h10FFFFFF);
    cyc();
    chk("full_win16", dv(), 32'hFFFFFFFF);
    drive(0, 0, 1, 0, 0);

    // single pattern, step every cycle
    short_seq = '{32'hC0FFFFFF, 32'hFFFFFFFF, 32'hFFFFFFC0,
                  32'hFFFFC0FF, 32'hFFC0FFFF};
    drive(1, 8'hC0, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    chk("short_0", dv(), short_seq[0]);
    for (int j = 1; j < 11; j++) begin
      cyc();
      chk($sformatf("short_%0d", j), dv(), short_seq[j % 5]);
    end
    drive(0, 0, 1, 0, 0);

    // reset in the middle of a run
    tick_div = 26'd3;
    for (int i = 0; i < 5; i++) drive(1, msg5[i], 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    repeat (10) cyc();
    chk("mid_run_d", dv(), 32'hA4B099FF);
    reset = 1;
    cyc();
    reset = 0;
    chk("mid_reset_d", dv(), 32'hFFFF_FFFF);
    chk("mid_reset_busy", busy, 0);
    chk("mid_reset_len", len, 0);

    // randomized run against the reference model
    drive(0, 0, 1, 0, 0);
    mq.delete(); m_mode = 0; m_pos = 0; m_cnt = 0;
    tick_div = 26'($urandom_range(0, 3));
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) == 0)
        tick_div = 26'($urandom_range(0, 4));
      w  = ($urandom_range(0, 2) == 0);
      wd = 8'($urandom);
      c  = ($urandom_range(0, 59) == 0);
      s  = ($urandom_range(0, 7) == 0);
      p  = ($urandom_range(0, 11) == 0);
      m_step(w, wd, c, s, p, int'(tick_div));
      drive(w, wd, c, s, p);
      chk("rand_d", dv(), m_win());
      chk("rand_len", len, mq.size());
      chk("rand_busy", busy, m_mode != 0);
      chk("rand_full", full, mq.size() == N);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/disp_scroll_ctrl.md
Name: disp_scroll_ctrl

Overview:
- Sequencer for the 4-digit time-multiplexed 7-seg display driver.
- Holds a short message of raw segment patterns and drives the driver's four 8-bit pattern inputs.
- Scrolls the message right-to-left across the digits at a programmable rate.
- Supports start, pause/resume and clear control from switches, buttons or a CPU register block.

Parameters:
- N_MSG, 16: message buffer depth in patterns (power of 2, ≥4); ADDR_W = log2(N_MSG).
- TICK_W, 26: width of the scroll-period divider input.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  append wr_data to message (1-cycle strobe)
- wr_data  in  8  segment pattern (active-low segments, bit 7 = dp)
- clr  in  1  clear message and stop
- start  in  1  start or resume scrolling (strobe)
- stop  in  1  pause, or abort when already paused (strobe)
- tick_div  in  TICK_W  scroll step period = tick_div+1 clk cycles
- len  out  ADDR_W+1  number of stored patterns
- full  out  1  len == N_MSG
- busy  out  1  state != IDLE
- d3, d2, d1, d0  out  8 each  digit patterns to the driver inputs in3..in0 (d3 = leftmost)

Behaviour:
- Reset: state IDLE, len=0, pos=0, prescaler cnt=0, d3..d0=BLANK (8'hFF), busy=0, full=0.
- Buffer contents are don't-care after reset.
- Scroll stream: s[i] = mem[i] for i<len, BLANK for len≤i<L, where L = len+4 (four trailing blanks).
- window(p): d3=s[p], d2=s[(p+1) mod L], d1=s[(p+2) mod L], d0=s[(p+3) mod L].
- All outputs are registered. On the edge that loads pos=p in RUN/HOLD, d3..d0 load window(p) on that same edge (zero extra latency).
- Writes are accepted only in IDLE with len<N_MSG: mem[len]<=wr_data, len<=len+1. All other writes are silently ignored (full does not wrap).
- FSM:
  - IDLE: start with len>0 → RUN, pos=0, cnt=0, d=window(0). start with len==0 → stay IDLE. d=BLANK throughout.
  - RUN: cnt increments each cycle. When cnt ≥ tick_div: cnt<=0, pos<=(pos==L-1)?0:pos+1, d=window(next pos). stop → HOLD with cnt and pos frozen.
  - HOLD: outputs frozen. start → RUN, resuming with the frozen cnt. stop → IDLE, pos=0, d=BLANK.
- The ≥ comparison makes lowering tick_div mid-run take effect immediately, with no 2^TICK_W wrap.
- tick_div=0: one step per cycle.
- Priority, same cycle: reset > clr > stop > start > wr_en.
  - clr from any state: IDLE, len=0, pos=0, cnt=0, d=BLANK.
  - start and stop together in RUN: stop wins (→HOLD).
  - start and stop together in IDLE: no effect.
- wr_en together with start in IDLE: the write is ignored and start proceeds with the pre-write len.
- len is stable while busy, so L is constant during a run.

Decomposition:
- Package disp_pkg:
  - BLANK = 8'hFF
  - state_t enum {IDLE, RUN, HOLD}
  - function win_idx(p, k, L) returning (p+k) mod L without a divider (conditional subtract; valid since p<L and k≤3<L)
- One sub-module, scroll_tick_gen: holds cnt. Inputs tick_div, en (RUN), clr (restart). Output 1-cycle tick.
- The message buffer is a plain register array inside disp_scroll_ctrl.

Test Plan:
- Reset mid-RUN (message from the scroll test, several steps in) → next cycle d3..d0=FF,FF,FF,FF, busy=0, len=0.
- Scroll: write C0,F9,A4,B0,99 (len=5, L=9), tick_div=3, start.
  - Edge after start: d3..d0=C0,F9,A4,B0.
  - +4 cycles: F9,A4,B0,99.
  - +8: A4,B0,99,FF.
  - +36 cycles after start: back to C0,F9,A4,B0.
- Pause/resume: in RUN with cnt=2, stop → outputs frozen for 50 cycles; start → next step exactly 2 cycles after resume (cnt 2→3). stop twice → IDLE, all FF.
- Full and ignore:
  - Write 17 patterns (N_MSG=16) → len=16, full=1, 17th dropped.
  - wr_en during RUN → len unchanged.
  - start with len=0 → busy stays 0.
- Priority: clr+stop+start in the same RUN cycle → IDLE, len=0, all FF. start+stop in RUN → HOLD.
- Short message and fast tick: len=1 (C0), tick_div=0 → sequence C0,FF,FF,FF / FF,FF,FF,FF / FF,FF,FF,C0 / FF,FF,C0,FF / FF,C0,FF,FF, repeating with period 5 cycles.
